// File: rtl/hyperram_arb_pkg.sv
// Shared definitions for the HyperRAM port arbiter.
//   arb_state_t      : arbiter FSM states
//   RD_TIMEOUT_DATA  : data returned to a requester when a read times out
//   MIN_GAP          : smallest legal idle gap between controller pulses
//   cnt_width()      : width of a saturating counter that can reach max(a, b)
package hyperram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT_RD = 3'd2,
    WAIT_WR = 3'd3,
    GAP     = 3'd4
  } arb_state_t;

  localparam logic [31:0] RD_TIMEOUT_DATA = 32'hDEAD_BEEF;
  localparam int          MIN_GAP         = 2;

  // One spare bit above clog2 so the terminal count itself is representable.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/hyperram_port_arbiter_if.sv
// Bus bundle between the requesters and the arbiter, and between the arbiter
// and the controller s0 port.
//   r_*  : per-requester Avalon-MM-style slave side (NUM_REQ lanes)
//   m_*  : single master side towards the HyperRAM controller
// Modports: slave = arbiter view, master = requester/controller (bench) view.
interface hyperram_port_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ*32-1:0] r_address;
  logic [NUM_REQ-1:0]    r_read;
  logic [NUM_REQ-1:0]    r_write;
  logic [NUM_REQ*32-1:0] r_writedata;
  logic [NUM_REQ-1:0]    r_waitrequest;
  logic [31:0]           r_readdata;
  logic [NUM_REQ-1:0]    r_readdatavalid;
  logic [31:0]           m_address;
  logic                  m_read;
  logic                  m_write;
  logic [31:0]           m_writedata;
  logic [31:0]           m_readdata;
  logic                  m_readdatavalid;

  modport slave (
    input  r_address, r_read, r_write, r_writedata,
    output r_waitrequest, r_readdata, r_readdatavalid,
    output m_address, m_read, m_write, m_writedata,
    input  m_readdata, m_readdatavalid
  );

  modport master (
    output r_address, r_read, r_write, r_writedata,
    input  r_waitrequest, r_readdata, r_readdatavalid,
    input  m_address, m_read, m_write, m_writedata,
    output m_readdata, m_readdatavalid
  );
endinterface

// File: rtl/hyperram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr_i, wrapping modulo NUM_REQ.
//   req_i       : request vector
//   ptr_i       : highest-priority index this cycle (must be < NUM_REQ)
//   grant_o     : one-hot grant
//   grant_idx_o : index of the granted request
//   any_req_o   : at least one request is asserted
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      grant_idx_o,
  output logic               any_req_o
);

  // Scan from the pointer and keep the first hit.
  always_comb begin
    int          idx;
    logic [IW-1:0] sel;
    grant_o     = '0;
    grant_idx_o = '0;
    any_req_o   = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      sel = IW'(idx);
      if (!any_req_o && req_i[sel]) begin
        any_req_o   = 1'b1;
        grant_o     = '0;
        grant_o[sel] = 1'b1;
        grant_idx_o = sel;
      end else begin
        any_req_o   = any_req_o;
      end
    end
  end

endmodule

// File: rtl/hyperram_port_arbiter.sv
// Shares the single s0 port of the HyperRAM controller between NUM_REQ
// requesters. One transaction at a time, round-robin, each issued as a
// one-cycle m_read/m_write pulse followed by guaranteed idle cycles so the
// controller's edge detector always sees a fresh rising edge.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : requester lanes and controller port (slave modport)
//   busy        : FSM is not IDLE
//   timeout_err : sticky read-timeout flag, cleared only by rst
module hyperram_port_arbiter
  import hyperram_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_TIMEOUT = 1024,
  parameter int WR_GUARD   = 256,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  hyperram_port_arbiter_if.slave   bus,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_EFF = (GAP_CYCLES < MIN_GAP) ? MIN_GAP : GAP_CYCLES;
  localparam int CW      = cnt_width(RD_TIMEOUT, (WR_GUARD > GAP_EFF) ? WR_GUARD : GAP_EFF);

  localparam logic [CW-1:0] RD_LAST  = CW'(RD_TIMEOUT - 1);
  localparam logic [CW-1:0] WR_LAST  = CW'(WR_GUARD);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_EFF - 1);

  arb_state_t          state_q;
  logic [IW-1:0]       rr_ptr_q;
  logic [IW-1:0]       owner_q;
  logic                is_rd_q;
  logic [CW-1:0]       cnt_q;
  logic [31:0]         m_address_q;
  logic [31:0]         m_writedata_q;
  logic                m_read_q;
  logic                m_write_q;
  logic [31:0]         r_readdata_q;
  logic [NUM_REQ-1:0]  r_rdv_q;
  logic                timeout_err_q;

  logic [NUM_REQ-1:0]  pending_s;
  logic [NUM_REQ-1:0]  grant_s;
  logic [IW-1:0]       grant_idx_s;
  logic                any_s;
  logic [31:0]         addr_sel_s;
  logic [31:0]         wdata_sel_s;
  logic                rd_sel_s;
  logic [IW-1:0]       next_ptr_d;
  logic [CW-1:0]       cnt_inc_s;
  logic [NUM_REQ-1:0]  owner_oh_s;
  logic [NUM_REQ-1:0]  waitreq_s;

  assign pending_s = bus.r_read | bus.r_write;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req_i       (pending_s),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s),
    .any_req_o   (any_s)
  );

  // Read wins when a requester asserts both; the accept consumes both.
  assign rd_sel_s   = |(bus.r_read & grant_s);
  assign cnt_inc_s  = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;
  assign owner_oh_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;

  // Select the granted lane's address and write data.
  always_comb begin
    addr_sel_s  = 32'h0000_0000;
    wdata_sel_s = 32'h0000_0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        addr_sel_s  = bus.r_address[i*32 +: 32];
        wdata_sel_s = bus.r_writedata[i*32 +: 32];
      end else begin
        addr_sel_s  = addr_sel_s;
        wdata_sel_s = wdata_sel_s;
      end
    end
  end

  // Pointer moves to the slot after the winner.
  always_comb begin
    next_ptr_d = rr_ptr_q;
    if (grant_idx_s == IW'(NUM_REQ - 1)) begin
      next_ptr_d = '0;
    end else begin
      next_ptr_d = grant_idx_s + 1'b1;
    end
  end

  // Accept is combinational: waitrequest drops only for the IDLE-cycle winner.
  always_comb begin
    waitreq_s = {NUM_REQ{1'b1}};
    if ((state_q == IDLE) && !rst && any_s) begin
      waitreq_s = ~grant_s;
    end else begin
      waitreq_s = {NUM_REQ{1'b1}};
    end
  end

  // Arbiter FSM with registered controller and requester outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      is_rd_q       <= 1'b0;
      cnt_q         <= '0;
      m_address_q   <= 32'h0000_0000;
      m_writedata_q <= 32'h0000_0000;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      r_readdata_q  <= 32'h0000_0000;
      r_rdv_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // Pulses last one cycle unless a branch below re-asserts them.
      r_rdv_q   <= '0;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_s) begin
            m_address_q   <= addr_sel_s;
            m_writedata_q <= wdata_sel_s;
            owner_q       <= grant_idx_s;
            is_rd_q       <= rd_sel_s;
            rr_ptr_q      <= next_ptr_d;
            cnt_q         <= '0;
            m_read_q      <= rd_sel_s;
            m_write_q     <= !rd_sel_s;
            state_q       <= ISSUE;
          end else begin
            state_q       <= IDLE;
          end
        end
        ISSUE: begin
          // The read timeout window starts with the pulse cycle itself.
          cnt_q   <= cnt_inc_s;
          state_q <= is_rd_q ? WAIT_RD : WAIT_WR;
        end
        WAIT_RD: begin
          if (bus.m_readdatavalid) begin
            r_readdata_q <= bus.m_readdata;
            r_rdv_q      <= owner_oh_s;
            cnt_q        <= '0;
            state_q      <= GAP;
          end else if (cnt_q >= RD_LAST) begin
            r_readdata_q  <= RD_TIMEOUT_DATA;
            r_rdv_q       <= owner_oh_s;
            timeout_err_q <= 1'b1;
            cnt_q         <= '0;
            state_q       <= GAP;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        WAIT_WR: begin
          // Entered with cnt=1, so WR_GUARD cycles are spent here.
          if (cnt_q >= WR_LAST) begin
            cnt_q   <= '0;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        GAP: begin
          if (cnt_q >= GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_inc_s;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.r_waitrequest   = waitreq_s;
  assign bus.r_readdata      = r_readdata_q;
  assign bus.r_readdatavalid = r_rdv_q;
  assign bus.m_address       = m_address_q;
  assign bus.m_read          = m_read_q;
  assign bus.m_write         = m_write_q;
  assign bus.m_writedata     = m_writedata_q;
  assign busy                = (state_q != IDLE);
  assign timeout_err         = timeout_err_q;

endmodule

// File: tb/tb_hyperram_port_arbiter.sv
// Directed bench for hyperram_port_arbiter. dut_a (RD_TIMEOUT=64, WR_GUARD=8)
// covers arbitration, reads, writes and reset; dut_b (RD_TIMEOUT=16) covers
// the read timeout. Inputs change and outputs are sampled on the falling edge.
module tb_hyperram_port_arbiter;

  logic clk;
  logic rst;
  logic busy_a, terr_a, busy_b, terr_b;

  hyperram_port_arbiter_if #(.NUM_REQ(2)) bus_a ();
  hyperram_port_arbiter_if #(.NUM_REQ(2)) bus_b ();

  hyperram_port_arbiter #(.NUM_REQ(2), .RD_TIMEOUT(64), .WR_GUARD(8), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .busy(busy_a), .timeout_err(terr_a)
  );

  hyperram_port_arbiter #(.NUM_REQ(2), .RD_TIMEOUT(16), .WR_GUARD(8), .GAP_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .busy(busy_b), .timeout_err(terr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Activity monitor for dut_a; cyc equals the cycle index seen at a falling edge.
  int         cyc        = 0;
  int         rd_pulses  = 0;
  int         wr_pulses  = 0;
  int         rdv_cnt    = 0;
  int         rdv_cyc    = 0;
  int         last_pulse = 0;
  int         min_gap    = 1000;
  logic       have_prev  = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus_a.m_read) rd_pulses <= rd_pulses + 1;
    if (bus_a.m_write) wr_pulses <= wr_pulses + 1;
    if (bus_a.m_read || bus_a.m_write) begin
      if (have_prev && (cyc - last_pulse - 1) < min_gap) min_gap <= cyc - last_pulse - 1;
      last_pulse <= cyc;
      have_prev  <= 1'b1;
    end
    if (bus_a.r_readdatavalid != 2'b00) begin
      rdv_cnt <= rdv_cnt + 1;
      rdv_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Both requesters read at once; 'first' must win, then the other one.
  task automatic read_pair(input int first, input logic [31:0] d1, input logic [31:0] d2);
    logic [1:0]  oh1, oh2, wm1, wm2;
    logic [31:0] a1, a2;
    oh1 = (first == 0) ? 2'b01 : 2'b10;
    oh2 = ~oh1;
    wm1 = oh2;
    wm2 = oh1;
    a1  = (first == 0) ? 32'h0000_0200 : 32'h0000_0300;
    a2  = (first == 0) ? 32'h0000_0300 : 32'h0000_0200;
    bus_a.r_read = 2'b11;
    #1;
    check("pair_grant1", bus_a.r_waitrequest, wm1);
    @(negedge clk);
    bus_a.r_read = oh2;
    check("pair_mread1", bus_a.m_read, 1'b1);
    check("pair_addr1", bus_a.m_address, a1);
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b1;
    bus_a.m_readdata      = d1;
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b0;
    check("pair_rdv1", bus_a.r_readdatavalid, oh1);
    check("pair_data1", bus_a.r_readdata, d1);
    @(negedge clk);
    check("pair_hold_in_gap", bus_a.r_waitrequest, 2'b11);
    check("pair_low_in_gap", bus_a.m_read, 1'b0);
    @(negedge clk);
    check("pair_grant2", bus_a.r_waitrequest, wm2);
    @(negedge clk);
    bus_a.r_read = 2'b00;
    check("pair_mread2", bus_a.m_read, 1'b1);
    check("pair_addr2", bus_a.m_address, a2);
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b1;
    bus_a.m_readdata      = d2;
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b0;
    check("pair_rdv2", bus_a.r_readdatavalid, oh2);
    check("pair_data2", bus_a.r_readdata, d2);
    repeat (2) @(negedge clk);
  endtask

  int t0, snap_rd, snap_wr, snap_rdv, busy_n, early;

  initial begin
    bus_a.r_address = '0; bus_a.r_read = '0; bus_a.r_write = '0; bus_a.r_writedata = '0;
    bus_a.m_readdata = 32'h0; bus_a.m_readdatavalid = 1'b0;
    bus_b.r_address = '0; bus_b.r_read = '0; bus_b.r_write = '0; bus_b.r_writedata = '0;
    bus_b.m_readdata = 32'h0; bus_b.m_readdatavalid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_waitreq", bus_a.r_waitrequest, 2'b11);
    check("rst_rdv", bus_a.r_readdatavalid, 2'b00);
    check("rst_rdata", bus_a.r_readdata, 32'h0);
    check("rst_mread", bus_a.m_read, 1'b0);
    check("rst_mwrite", bus_a.m_write, 1'b0);
    check("rst_maddr", bus_a.m_address, 32'h0);
    check("rst_mwdata", bus_a.m_writedata, 32'h0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_terr", terr_a, 1'b0);
    check("rst_terr_b", terr_b, 1'b0);
    rst = 1'b0;

    // Simultaneous reads from reset: req0 then req1
    bus_a.r_address = {32'h0000_0300, 32'h0000_0200};
    read_pair(0, 32'hA0A0_0001, 32'hA0A0_0002);

    // Single read from req0, 20-cycle controller latency
    bus_a.r_address[31:0] = 32'h0000_0040;
    snap_rd = rd_pulses; snap_rdv = rdv_cnt; t0 = cyc;
    bus_a.r_read = 2'b01;
    #1;
    check("t1_waitreq", bus_a.r_waitrequest, 2'b10);
    @(negedge clk);
    bus_a.r_read = 2'b00;
    check("t1_mread", bus_a.m_read, 1'b1);
    check("t1_maddr", bus_a.m_address, 32'h0000_0040);
    repeat (20) @(negedge clk);
    check("t1_no_early_rdv", rdv_cnt - snap_rdv, 0);
    bus_a.m_readdatavalid = 1'b1;
    bus_a.m_readdata      = 32'h1234_5678;
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b0;
    check("t1_rdv", bus_a.r_readdatavalid, 2'b01);
    check("t1_rdata", bus_a.r_readdata, 32'h1234_5678);
    @(negedge clk);
    check("t1_rdv_cycle", rdv_cyc - t0, 22);
    check("t1_rdv_count", rdv_cnt - snap_rdv, 1);
    check("t1_read_pulses", rd_pulses - snap_rd, 1);
    check("t1_rdv_one_cycle", bus_a.r_readdatavalid, 2'b00);
    @(negedge clk);

    // Pointer now at req1: second pair goes req1 then req0
    bus_a.r_address = {32'h0000_0300, 32'h0000_0200};
    read_pair(1, 32'hB0B0_0001, 32'hB0B0_0002);

    // Write from req1 while a req0 read becomes pending
    bus_a.r_address   = {32'h0000_0100, 32'h0000_0080};
    bus_a.r_writedata = {32'hCAFE_F00D, 32'h0000_0000};
    snap_wr = wr_pulses;
    bus_a.r_write = 2'b10;
    #1;
    check("t3_waitreq", bus_a.r_waitrequest, 2'b01);
    @(negedge clk);
    bus_a.r_write = 2'b00;
    bus_a.r_read  = 2'b01;
    check("t3_mwrite", bus_a.m_write, 1'b1);
    check("t3_no_mread", bus_a.m_read, 1'b0);
    check("t3_maddr", bus_a.m_address, 32'h0000_0100);
    check("t3_mwdata", bus_a.m_writedata, 32'hCAFE_F00D);
    busy_n = 0; early = 0;
    for (int i = 0; i < 11; i++) begin
      if (busy_a) busy_n++;
      if (bus_a.r_waitrequest != 2'b11) early++;
      @(negedge clk);
    end
    check("t3_busy_cycles", busy_n, 11);
    check("t3_no_early_grant", early, 0);
    check("t3_busy_done", busy_a, 1'b0);
    check("t3_grant_after_gap", bus_a.r_waitrequest, 2'b10);
    @(negedge clk);
    bus_a.r_read = 2'b00;
    check("t3_mread", bus_a.m_read, 1'b1);
    check("t3_maddr_rd", bus_a.m_address, 32'h0000_0080);
    check("t3_write_pulses", wr_pulses - snap_wr, 1);
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b1;
    bus_a.m_readdata      = 32'h55AA_1234;
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b0;
    check("t3_rdv", bus_a.r_readdatavalid, 2'b01);
    check("t3_rdata", bus_a.r_readdata, 32'h55AA_1234);
    repeat (2) @(negedge clk);

    // Read and write together from req0: one read only
    bus_a.r_address[31:0] = 32'h0000_0044;
    snap_wr = wr_pulses;
    bus_a.r_read  = 2'b01;
    bus_a.r_write = 2'b01;
    #1;
    check("t6_waitreq", bus_a.r_waitrequest, 2'b10);
    @(negedge clk);
    bus_a.r_read  = 2'b00;
    bus_a.r_write = 2'b00;
    check("t6_mread", bus_a.m_read, 1'b1);
    check("t6_no_mwrite", bus_a.m_write, 1'b0);
    check("t6_maddr", bus_a.m_address, 32'h0000_0044);
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b1;
    bus_a.m_readdata      = 32'h0000_4444;
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b0;
    check("t6_rdv", bus_a.r_readdatavalid, 2'b01);
    check("t6_rdata", bus_a.r_readdata, 32'h0000_4444);
    repeat (2) @(negedge clk);
    check("t6_write_pulses", wr_pulses - snap_wr, 0);

    // Reset during WAIT_RD, then a late valid
    bus_a.r_address = {32'h0000_0300, 32'h0000_0200};
    bus_a.r_read = 2'b10;
    #1;
    check("t5_waitreq", bus_a.r_waitrequest, 2'b01);
    @(negedge clk);
    bus_a.r_read = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    snap_rdv = rdv_cnt;
    check("t5_busy", busy_a, 1'b0);
    check("t5_mread", bus_a.m_read, 1'b0);
    check("t5_rdv", bus_a.r_readdatavalid, 2'b00);
    check("t5_rdata", bus_a.r_readdata, 32'h0);
    check("t5_maddr", bus_a.m_address, 32'h0);
    check("t5_waitreq_idle", bus_a.r_waitrequest, 2'b11);
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b1;
    bus_a.m_readdata      = 32'h9999_9999;
    @(negedge clk);
    bus_a.m_readdatavalid = 1'b0;
    check("t5_late_valid_ignored", bus_a.r_readdatavalid, 2'b00);
    check("t5_still_idle", busy_a, 1'b0);
    @(negedge clk);
    check("t5_no_rdv", rdv_cnt - snap_rdv, 0);
    read_pair(0, 32'hC0C0_0001, 32'hC0C0_0002);
    check("gap_min", (min_gap >= 2) ? 32'd1 : 32'd0, 32'd1);
    check("a_no_timeout", terr_a, 1'b0);

    // dut_b: valid exactly at the timeout expiry cycle wins
    bus_b.r_address = {32'h0000_0000, 32'h0000_0010};
    bus_b.r_read = 2'b01;
    #1;
    check("t4_waitreq", bus_b.r_waitrequest, 2'b10);
    @(negedge clk);
    bus_b.r_read = 2'b00;
    check("t4_mread", bus_b.m_read, 1'b1);
    repeat (15) @(negedge clk);
    check("t4_edge_no_rdv", bus_b.r_readdatavalid, 2'b00);
    bus_b.m_readdatavalid = 1'b1;
    bus_b.m_readdata      = 32'h7777_0001;
    @(negedge clk);
    bus_b.m_readdatavalid = 1'b0;
    check("t4_edge_rdv", bus_b.r_readdatavalid, 2'b01);
    check("t4_edge_rdata", bus_b.r_readdata, 32'h7777_0001);
    check("t4_edge_no_err", terr_b, 1'b0);
    repeat (2) @(negedge clk);

    // dut_b: no response at all
    bus_b.r_read = 2'b01;
    @(negedge clk);
    bus_b.r_read = 2'b00;
    check("t4_to_mread", bus_b.m_read, 1'b1);
    repeat (15) @(negedge clk);
    check("t4_to_not_yet", bus_b.r_readdatavalid, 2'b00);
    @(negedge clk);
    check("t4_to_rdv", bus_b.r_readdatavalid, 2'b01);
    check("t4_to_rdata", bus_b.r_readdata, 32'hDEAD_BEEF);
    check("t4_to_err", terr_b, 1'b1);
    repeat (2) @(negedge clk);

    // dut_b: later good read keeps the sticky error
    bus_b.r_read = 2'b01;
    @(negedge clk);
    bus_b.r_read = 2'b00;
    @(negedge clk);
    bus_b.m_readdatavalid = 1'b1;
    bus_b.m_readdata      = 32'h0BAD_F00D;
    @(negedge clk);
    bus_b.m_readdatavalid = 1'b0;
    check("t4_good_rdv", bus_b.r_readdatavalid, 2'b01);
    check("t4_good_rdata", bus_b.r_readdata, 32'h0BAD_F00D);
    check("t4_err_sticky", terr_b, 1'b1);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hyperram_port_arbiter.md
Name: hyperram_port_arbiter

Overview:
- Shares the single s0 memory port of the HyperRAM controller between NUM_REQ Avalon-MM-style requesters (e.g. CPU and DMA).
- Grants one transaction at a time, round-robin, and drives the controller with one-cycle read/write pulses separated by guaranteed idle cycles, so the controller's rising-edge detection always fires.
- Returns read data only to the owning requester; bounds every read with a timeout.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- RD_TIMEOUT, 1024, max cycles from read pulse to m_readdatavalid before forced completion.
- WR_GUARD, 256, cycles held busy after a write pulse (controller has no write-done signal; covers miss read-modify-writeback plus ACCDLY).
- GAP_CYCLES, 2, minimum low cycles on m_read/m_write between pulses (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- r_address  in  NUM_REQ*32  per-requester byte address, slice i = bits [32i+31:32i]
- r_read  in  NUM_REQ  per-requester read request, level, held until accepted
- r_write  in  NUM_REQ  per-requester write request, level, held until accepted
- r_writedata  in  NUM_REQ*32  per-requester write data
- r_waitrequest  out  NUM_REQ  low only in the accept cycle of requester i
- r_readdata  out  32  read data, shared bus, qualified by r_readdatavalid
- r_readdatavalid  out  NUM_REQ  one-cycle pulse to the owning requester
- m_address  out  32  to controller s0_address
- m_read  out  1  to controller s0_read
- m_write  out  1  to controller s0_write
- m_writedata  out  32  to controller s0_writedata
- m_readdata  in  32  from controller s0_readdata
- m_readdatavalid  in  1  from controller s0_readdatavalid
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  sticky; set on read timeout, cleared only by rst

Behaviour:
- Reset values: r_waitrequest all 1, r_readdatavalid 0, r_readdata 0, m_read/m_write 0, m_address/m_writedata 0, busy 0, timeout_err 0, rr pointer 0, state IDLE.
- Reset mid-transaction: immediate return to IDLE; outstanding read dropped, no r_readdatavalid issued.
- States: IDLE, ISSUE, WAIT_RD, WAIT_WR, GAP.
- Arbitration (IDLE):
  - Pending[i] = r_read[i] | r_write[i].
  - Winner = first pending index at or after rr pointer, wrapping modulo NUM_REQ.
  - r_waitrequest[winner] = 0 combinationally in that cycle; all others stay 1.
  - Latch address, writedata, owner, and direction; rr pointer <= winner+1 mod NUM_REQ; go to ISSUE.
- Read and write asserted together by one requester: treated as a read, and both are consumed by the accept.
- ISSUE (1 cycle): m_read or m_write = 1 with latched m_address/m_writedata; next state WAIT_RD (read) or WAIT_WR (write). m_address/m_writedata stay stable until the next accept.
- WAIT_RD:
  - Counter counts from 0.
  - On m_readdatavalid: next cycle r_readdata <= m_readdata and r_readdatavalid[owner] = 1; go to GAP.
  - If counter reaches RD_TIMEOUT-1 without valid: r_readdata <= 32'hDEAD_BEEF, r_readdatavalid[owner] pulses, timeout_err <= 1; go to GAP.
  - Valid arriving in the same cycle as the timeout expiry: valid wins, no error.
- WAIT_WR: count WR_GUARD cycles, then go to GAP. No acknowledgement to the requester beyond the accept cycle.
- GAP: GAP_CYCLES cycles with m_read = m_write = 0, then IDLE.
- m_readdatavalid outside WAIT_RD is ignored.
- Read latency: accept at cycle 0; m_read high at cycle 1; controller valid at cycle N; r_readdatavalid at N+1.
- Back-to-back issue spacing: at least 1 + GAP_CYCLES + 1 cycles between m_read/m_write pulses (write: + WR_GUARD).
- Counters are clog2(max(RD_TIMEOUT,WR_GUARD))+1 bits wide and saturate; no wrap.
- Requesters must hold address and data stable while r_waitrequest = 1 (Avalon rule). Dropping a request before accept withdraws it with no side effect.

Decomposition:
- Package hyperram_arb_pkg: arb_state_t enum (IDLE, ISSUE, WAIT_RD, WAIT_WR, GAP), RD_TIMEOUT_DATA = 32'hDEAD_BEEF, MIN_GAP = 2.
- Sub-module rr_arbiter: combinational round-robin pick, with inputs req[NUM_REQ] and ptr, and outputs grant one-hot plus grant_idx and any_req. It is reused for the CSR port later.

Test Plan:
- Single read from req0 at address 0x40, controller model returns 0x1234_5678 after 20 cycles -> r_waitrequest[0] low 1 cycle, one m_read pulse with m_address = 0x40, r_readdatavalid[0] pulses at accept+22 with 0x1234_5678, r_readdatavalid[1] stays 0.
- req0 and req1 both read from reset -> req0 granted first, then req1. A second simultaneous pair is granted req1 then req0 (pointer rotation). m_read pulses are separated by >= 2 low cycles.
- Write from req1 (address 0x100, data 0xCAFE_F00D) with WR_GUARD=8 -> one m_write pulse carrying that address and data, busy high for 1+8+2 cycles, and a pending req0 read is not issued before the GAP ends.
- Read with controller never responding, RD_TIMEOUT=16 -> r_readdatavalid pulses 16 cycles after m_read with 0xDEAD_BEEF, timeout_err = 1 and stays 1 over later good reads.
- rst asserted during WAIT_RD, then late m_readdatavalid -> all outputs at reset values, no r_readdatavalid, next request arbitrated from req0.
- req0 asserts r_read and r_write together -> single m_read pulse only, no m_write.
